// File: rtl/reset_seq_pkg.sv
// Shared state encoding and default timing constants for the AHB2APB reset sequencer.
package reset_seq_pkg;

  typedef enum logic [2:0] {IDLE, DRAIN, ASSERT, GAP, DONE} rst_state_e;

  localparam int unsigned DEF_NUM_REQ       = 3;
  localparam int unsigned DEF_ASSERT_CYCLES = 8;
  localparam int unsigned DEF_GAP_CYCLES    = 4;
  localparam int unsigned DEF_DRAIN_TIMEOUT = 16;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/reset_sequencer.sv
// Arbitrates reset requests, drains bus traffic, then releases the APB reset before the AHB reset.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned NUM_REQ       = DEF_NUM_REQ,
  parameter int unsigned ASSERT_CYCLES = DEF_ASSERT_CYCLES,
  parameter int unsigned GAP_CYCLES    = DEF_GAP_CYCLES,
  parameter int unsigned DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               bus_idle_i,
  output logic               hresetn_o,
  output logic               presetn_o,
  output logic               busy_o,
  output logic [NUM_REQ-1:0] ack_o,
  output logic [NUM_REQ-1:0] cause_o,
  output logic               timeout_flag_o
);

  localparam int unsigned CNT_W = $clog2(max3(ASSERT_CYCLES, GAP_CYCLES, DRAIN_TIMEOUT) + 1);

  localparam logic [CNT_W-1:0] ASSERT_LAST = CNT_W'(ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_TIMEOUT - 1);

  rst_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] pend_q, pend_d;
  logic [NUM_REQ-1:0] cause_q, cause_d;
  logic               timeout_q, timeout_d;

  // The counter is shared by every timed state and restarts on each state entry.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    cause_d   = cause_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          pend_d    = req_i;
          cause_d   = req_i;
          timeout_d = 1'b0;
          cnt_d     = '0;
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        pend_d  = pend_q | req_i;
        cause_d = cause_q | req_i;
        if (bus_idle_i) begin
          cnt_d   = '0;
          state_d = ASSERT;
        end else if (cnt_q == DRAIN_LAST) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = ASSERT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ASSERT: begin
        if (cnt_q == ASSERT_LAST) begin
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        pend_d  = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ASSERT;
      end
    endcase
  end

  // Power-on reset lands in ASSERT so the bridge sees a full ordered release.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ASSERT;
      cnt_q     <= '0;
      pend_q    <= '0;
      cause_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      cause_q   <= cause_d;
      timeout_q <= timeout_d;
    end
  end

  assign presetn_o      = (state_q != ASSERT);
  assign hresetn_o      = (state_q != ASSERT) && (state_q != GAP);
  assign busy_o         = (state_q != IDLE);
  assign ack_o          = (state_q == DONE) ? pend_q : '0;
  assign cause_o        = cause_q;
  assign timeout_flag_o = timeout_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench: directed scenarios plus a randomized run against a timeline reference model.
module tb_reset_sequencer;

  localparam int NR = 3;
  localparam int AC = 8;
  localparam int GC = 4;
  localparam int DT = 16;
  localparam int OW = 3 + 2 * NR;
  localparam int N  = 500;
  localparam int NS = N + 64;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          bus_idle_i;
  logic [NR-1:0] req_i;
  logic          hresetn_o;
  logic          presetn_o;
  logic          busy_o;
  logic [NR-1:0] ack_o;
  logic [NR-1:0] cause_o;
  logic          timeout_flag_o;

  int checks = 0;
  int errors = 0;

  reset_sequencer #(
    .NUM_REQ      (NR),
    .ASSERT_CYCLES(AC),
    .GAP_CYCLES   (GC),
    .DRAIN_TIMEOUT(DT)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .req_i         (req_i),
    .bus_idle_i    (bus_idle_i),
    .hresetn_o     (hresetn_o),
    .presetn_o     (presetn_o),
    .busy_o        (busy_o),
    .ack_o         (ack_o),
    .cause_o       (cause_o),
    .timeout_flag_o(timeout_flag_o)
  );

  always #5 clk = ~clk;

  // Output vector layout everywhere: {hresetn, presetn, busy, ack, cause, timeout_flag}.
  task automatic test_reset();
    logic [OW-1:0] obs, expv;
    logic          expP, expH, expB;
    reset_i    = 1'b1;
    req_i      = '0;
    bus_idle_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    obs  = {hresetn_o, presetn_o, busy_o, ack_o, cause_o, timeout_flag_o};
    expv = {1'b0, 1'b0, 1'b1, {NR{1'b0}}, {NR{1'b0}}, 1'b0};
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL reset_hold got=%b expected=%b", obs, expv);
    end
    reset_i = 1'b0;
    for (int k = 0; k <= 15; k++) begin
      if (k > 0) @(negedge clk);
      expP = (k >= AC);
      expH = (k >= AC + GC);
      expB = (k < AC + GC + 1);
      obs  = {hresetn_o, presetn_o, busy_o, ack_o, cause_o, timeout_flag_o};
      expv = {expH, expP, expB, {NR{1'b0}}, {NR{1'b0}}, 1'b0};
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("[TB] FAIL power_on k=%0d got=%b expected=%b", k, obs, expv);
      end
    end
  endtask

  task automatic test_single();
    logic [OW-1:0] obs, expv;
    logic          expP, expH, expB;
    logic [NR-1:0] expA;
    req_i      = 3'b010;
    bus_idle_i = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      expP = !(k >= 2 && k <= 9);
      expH = !(k >= 2 && k <= 13);
      expB = (k <= 14);
      expA = (k == 14) ? 3'b010 : 3'b000;
      obs  = {hresetn_o, presetn_o, busy_o, ack_o, cause_o, timeout_flag_o};
      expv = {expH, expP, expB, expA, 3'b010, 1'b0};
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("[TB] FAIL single_req k=%0d got=%b expected=%b", k, obs, expv);
      end
      if (k == 14) req_i = '0;
    end
  endtask

  task automatic test_timeout();
    logic [OW-1:0] obs, expv;
    logic          expP, expH, expB, expT;
    logic [NR-1:0] expA;
    req_i      = 3'b001;
    bus_idle_i = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      @(negedge clk);
      expP = !(k >= DT + 1 && k <= DT + AC);
      expH = !(k >= DT + 1 && k <= DT + AC + GC);
      expB = (k <= DT + AC + GC + 1);
      expA = (k == DT + AC + GC + 1) ? 3'b001 : 3'b000;
      expT = (k >= DT + 1);
      obs  = {hresetn_o, presetn_o, busy_o, ack_o, cause_o, timeout_flag_o};
      expv = {expH, expP, expB, expA, 3'b001, expT};
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("[TB] FAIL drain_timeout k=%0d got=%b expected=%b", k, obs, expv);
      end
      if (k == DT + AC + GC + 1) req_i = '0;
    end
    bus_idle_i = 1'b1;
  endtask

  // req[2] arrives together with bus_idle on the last drain cycle; req[1] arrives too late and requeues.
  task automatic test_merge_requeue();
    logic [OW-1:0] obs, expv;
    logic          a1, g1, a2, g2, expB;
    logic [NR-1:0] expA, expC;
    req_i      = 3'b001;
    bus_idle_i = 1'b0;
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      a1   = (k >= 6 && k <= 13);
      g1   = (k >= 14 && k <= 17);
      a2   = (k >= 21 && k <= 28);
      g2   = (k >= 29 && k <= 32);
      expB = !(k == 19 || k >= 34);
      expA = (k == 18) ? 3'b101 : (k == 33) ? 3'b010 : 3'b000;
      expC = (k <= 5) ? 3'b001 : (k <= 19) ? 3'b101 : 3'b010;
      obs  = {hresetn_o, presetn_o, busy_o, ack_o, cause_o, timeout_flag_o};
      expv = {!(a1 || g1 || a2 || g2), !(a1 || a2), expB, expA, expC, 1'b0};
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("[TB] FAIL merge_requeue k=%0d got=%b expected=%b", k, obs, expv);
      end
      if (k == 5) begin
        req_i      = 3'b101;
        bus_idle_i = 1'b1;
      end
      if (k == 8)  req_i = 3'b111;
      if (k == 18) req_i = 3'b010;
      if (k == 33) req_i = 3'b000;
    end
  endtask

  task automatic test_reset_mid_gap();
    logic [OW-1:0] obs, expv;
    int            j;
    req_i      = 3'b100;
    bus_idle_i = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      if (k <= 11) begin
        expv = {!(k >= 2 && k <= 13), !(k >= 2 && k <= 9), 1'b1, 3'b000, 3'b100, 1'b0};
      end else begin
        j    = k - 12;
        expv = {(j >= AC + GC), (j >= AC), (j < AC + GC + 1), 3'b000, 3'b000, 1'b0};
      end
      obs = {hresetn_o, presetn_o, busy_o, ack_o, cause_o, timeout_flag_o};
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("[TB] FAIL reset_mid_gap k=%0d got=%b expected=%b", k, obs, expv);
      end
      if (k == 11) begin
        reset_i = 1'b1;
        req_i   = '0;
      end
      if (k == 12) reset_i = 1'b0;
    end
  endtask

  // Reference model walks the stimulus as a timeline of whole sequences rather than cycle-by-cycle state.
  task automatic test_random();
    logic [NR-1:0] reqv [NS];
    logic          idlev[NS];
    logic [OW-1:0] expv [N];
    logic [OW-1:0] obs;
    logic [NR-1:0] pend, cause;
    logic          tflag, drained;
    int            t, d, a, stuck, w;

    stuck = 0;
    for (int n = 0; n < NS; n++) begin
      reqv[n] = ($urandom_range(0, 5) == 0) ? NR'($urandom_range(1, (1 << NR) - 1)) : '0;
      if (stuck == 0 && $urandom_range(0, 40) == 0) stuck = $urandom_range(10, 24);
      if (stuck > 0) begin
        idlev[n] = 1'b0;
        stuck--;
      end else begin
        idlev[n] = ($urandom_range(0, 2) == 0);
      end
    end

    cause = '0;
    tflag = 1'b0;
    pend  = '0;
    t     = 0;
    while (t < N) begin
      expv[t] = {1'b1, 1'b1, 1'b0, {NR{1'b0}}, cause, tflag};
      if (|reqv[t]) begin
        pend    = reqv[t];
        cause   = reqv[t];
        tflag   = 1'b0;
        d       = t + 1;
        drained = 1'b0;
        while (!drained) begin
          if (d < N) expv[d] = {1'b1, 1'b1, 1'b1, {NR{1'b0}}, cause, tflag};
          pend  = pend | reqv[d];
          cause = cause | reqv[d];
          if (idlev[d]) begin
            drained = 1'b1;
          end else if (d == t + DT) begin
            tflag   = 1'b1;
            drained = 1'b1;
          end else begin
            d++;
          end
        end
        a = d + 1;
        for (int i = 0; i < AC; i++)
          if (a + i < N) expv[a + i] = {1'b0, 1'b0, 1'b1, {NR{1'b0}}, cause, tflag};
        for (int i = 0; i < GC; i++)
          if (a + AC + i < N) expv[a + AC + i] = {1'b0, 1'b1, 1'b1, {NR{1'b0}}, cause, tflag};
        if (a + AC + GC < N) expv[a + AC + GC] = {1'b1, 1'b1, 1'b1, pend, cause, tflag};
        t = a + AC + GC + 1;
      end else begin
        t++;
      end
    end

    req_i      = '0;
    bus_idle_i = 1'b1;
    reset_i    = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    w = 0;
    while (busy_o !== 1'b0 && w < 40) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL random_idle_wait got busy=%b expected=0 within 40 cycles", busy_o);
    end else begin
      for (int n = 0; n < N; n++) begin
        if (n > 0) @(negedge clk);
        obs = {hresetn_o, presetn_o, busy_o, ack_o, cause_o, timeout_flag_o};
        checks++;
        if (obs !== expv[n]) begin
          errors++;
          $display("[TB] FAIL random n=%0d got=%b expected=%b", n, obs, expv[n]);
        end
        req_i      = reqv[n];
        bus_idle_i = idlev[n];
      end
    end
    req_i      = '0;
    bus_idle_i = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_timeout();
    test_merge_requeue();
    test_reset_mid_gap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Reset controller for the AHB2APB bridge. It arbitrates reset requests from several requesters, drains in-flight bus traffic, and drives the bridge's AHB-side and APB-side resets in a fixed order. The APB side is released first, then the AHB side. Each requester is acknowledged once its sequence is complete. The block sits between the system reset/request sources and the bridge's `hresetn`/`presetn` inputs.

## Interface
Parameters:
- `NUM_REQ`, 3: number of reset requesters.
- `ASSERT_CYCLES`, 8: cycles both resets are held low (≥1).
- `GAP_CYCLES`, 4: cycles between `presetn` release and `hresetn` release (≥1).
- `DRAIN_TIMEOUT`, 16: maximum cycles spent waiting for `bus_idle` (≥1).

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high power-on reset.
- `req` in NUM_REQ: level reset requests; a requester drops its bit after its `ack`.
- `bus_idle` in 1: high when no AHB/APB transfer is in flight.
- `hresetn` out 1: AHB-side reset, active-low.
- `presetn` out 1: APB-side reset, active-low.
- `busy` out 1: a sequence is in progress.
- `ack` out NUM_REQ: one-cycle pulse, one bit per serviced requester.
- `cause` out NUM_REQ: mask of requesters serviced by the last or current sequence.
- `timeout_flag` out 1: the last drain ended by timeout.

## Operation
- Moore FSM with states IDLE, DRAIN, ASSERT, GAP, DONE, plus one shared up-counter `cnt` and a pending mask `pend`.
- All outputs are registered or decoded from the state register only.
- While `reset`=1:
  - state is forced to ASSERT; `cnt`, `pend`, `cause` and `timeout_flag` are cleared.
  - outputs: `hresetn`=0, `presetn`=0, `busy`=1, `ack`=0, `cause`=0, `timeout_flag`=0.
- IDLE (`hresetn`=1, `presetn`=1, `busy`=0):
  - if `|req`: set `pend`=`req`, `cause`=`req`, `timeout_flag`=0, `cnt`=0, then go to DRAIN.
- DRAIN (resets high, `busy`=1):
  - newly asserted `req` bits are OR-ed into `pend` and `cause`.
  - if `bus_idle`=1: go to ASSERT.
  - else if `cnt`==DRAIN_TIMEOUT-1: set `timeout_flag`=1 and go to ASSERT.
  - else `cnt`++.
- ASSERT (`hresetn`=0, `presetn`=0):
  - after ASSERT_CYCLES cycles, go to GAP.
  - `req` bits are ignored here and in all later states.
- GAP (`presetn`=1, `hresetn`=0): after GAP_CYCLES cycles, go to DONE.
- DONE (both resets high, `busy`=1):
  - `ack`=`pend` for exactly this cycle; clear `pend`; go to IDLE.
- Any request still high back in IDLE starts a new sequence. This includes requests raised after DRAIN.
- `cnt` is reset to 0 on every state entry.
- Counter width is $clog2(max(ASSERT_CYCLES, GAP_CYCLES, DRAIN_TIMEOUT)+1).
- `cause` and `timeout_flag` hold their values until the next IDLE→DRAIN transition or `reset`.

## Timing
- In IDLE, `req` is sampled at edge 0 and DRAIN is entered at edge 1.
  - With `bus_idle`=1 at edge 1, ASSERT is entered at edge 2.
  - `presetn` rises at edge 2+ASSERT_CYCLES.
  - `hresetn` rises and `ack` pulses at edge 2+ASSERT_CYCLES+GAP_CYCLES.
  - `busy` falls one cycle later.
- Drain with `bus_idle` stuck low lasts exactly DRAIN_TIMEOUT cycles.
- After `reset` deasserts, the ASSERT count starts at 0 in the first cycle with `reset` low.
  - `presetn` rises ASSERT_CYCLES cycles later.
  - `hresetn` rises ASSERT_CYCLES+GAP_CYCLES cycles later.
  - `ack`=0 throughout.
- Boundary cases:
  - `reset` asserted mid-sequence takes effect at the next edge and overrides all states.
  - `req` and `bus_idle` both rising in the same DRAIN cycle: the request merges and ASSERT follows.
  - Simultaneous requests share one sequence.

## Structure
- Package `reset_seq_pkg` holds:
  - `typedef enum logic [2:0] {IDLE, DRAIN, ASSERT, GAP, DONE} rst_state_e`;
  - default parameter constants.
- Single module with the counter inline; no sub-module.

## Test plan
Defaults are used unless stated; times count from the `req` sample edge unless stated.
- **Power-on:** `reset`=1 for 3 cycles, then 0 → `presetn` rises 8 cycles after release, `hresetn` after 12, `busy` falls after 13, `ack`=0, `cause`=0.
- **Single request:** `req`=3'b010, `bus_idle`=1 → resets low from edge 2 to edge 9, `presetn` high at 10, `hresetn` high at 14, `ack`=3'b010 for one cycle at 14, `cause`=3'b010, `timeout_flag`=0.
- **Drain timeout:** `bus_idle`=0 held, `req`=3'b001 → 16 DRAIN cycles, then ASSERT, `timeout_flag`=1, `ack`=3'b001.
- **Merge and requeue:**
  - `req`[0] raised in IDLE, `req`[2] raised during DRAIN (`bus_idle`=0) → `ack`=`cause`=3'b101.
  - `req`[1] raised during ASSERT → a second full sequence follows IDLE, `ack`=3'b010.
- **Reset mid-GAP:** assert `reset` while `presetn`=1, `hresetn`=0 → next edge `presetn`=0, `cause`=0, no `ack`; after release, the full 8+4 sequence replays.
